// File: rtl/hardware_trigger_dispatch.sv
// hardware_trigger_dispatch: watches 8 external pins against the trigger
// pattern from the store. It queues each rising match as a pending event
// and hands the events to the processor through a level IRQ with an Ack
// handshake.
module hardware_trigger_dispatch #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [7:0]       Trig,
  input  logic [7:0]       Pins,
  input  logic             En,
  input  logic             Ack,
  input  logic             Clear,
  output logic             IRQ,
  output logic [7:0]       Event,
  output logic [CNT_W-1:0] Pending,
  output logic             Overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [7:0]       s1_q, s1_d;
  logic [7:0]       s2_q, s2_d;
  logic             match_q, match_d;
  logic [7:0]       event_q, event_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             irq_q, irq_d;
  state_t           state_q, state_d;

  logic match;
  logic hit;
  logic dec;

  // Match the selected pins, find its rising edge, and detect an accepted acknowledge.
  always_comb begin
    match = En & (Trig != 8'h00) & ((s2_q & Trig) == Trig);
    hit   = match & ~match_q;
    dec   = (state_q == REQ) & Ack;
  end

  // Next-state logic for the synchronizer, event capture, pending queue and handshake FSM.
  always_comb begin
    s1_d       = Pins;
    s2_d       = s1_q;
    match_d    = match;
    event_d    = hit ? s2_q : event_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    case (state_q)
      IDLE:    if (pending_q != '0) state_d = REQ;
      REQ:     if (Ack) state_d = HOLD;
      HOLD:    if (!Ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (Clear) begin
      pending_d  = '0;
      overflow_d = 1'b0;
      state_d    = IDLE;
    end else if (hit && !dec) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_ONE;
      end
    end else if (dec && !hit && (pending_q != '0)) begin
      pending_d = pending_q - PEND_ONE;
    end

    irq_d = (state_d == REQ);
  end

  // Register all state; reset flushes everything, including queued events.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q       <= 8'h00;
      s2_q       <= 8'h00;
      match_q    <= 1'b0;
      event_q    <= 8'h00;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      state_q    <= IDLE;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      match_q    <= match_d;
      event_q    <= event_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
      state_q    <= state_d;
    end
  end

  assign IRQ      = irq_q;
  assign Event    = event_q;
  assign Pending  = pending_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_hardware_trigger_dispatch.sv
// Testbench for hardware_trigger_dispatch: directed stimulus; each IRQ
// rising edge is checked against a scoreboard of expected Event/Pending.
module tb_hardware_trigger_dispatch;

  typedef struct packed {
    logic [7:0] ev;
    logic [3:0] pend;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] trig;
  logic [7:0] pins;
  logic       en;
  logic       ack;
  logic       clear;
  logic       irq;
  logic [7:0] event_o;
  logic [3:0] pending;
  logic       overflow;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  hardware_trigger_dispatch #(.CNT_W(4)) dut (
    .CLK     (clk),
    .Reset_n (reset_n),
    .Trig    (trig),
    .Pins    (pins),
    .En      (en),
    .Ack     (ack),
    .Clear   (clear),
    .IRQ     (irq),
    .Event   (event_o),
    .Pending (pending),
    .Overflow(overflow)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] ev, input logic [3:0] pend);
    exp_t e;
    e.ev   = ev;
    e.pend = pend;
    sb_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [7:0] t, input logic [7:0] p, input logic e);
    trig = t;
    pins = p;
    en   = e;
  endtask

  task automatic handshake();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(2);
  endtask

  // Monitor: every IRQ rising edge must match the oldest scoreboard entry.
  initial begin
    logic irq_prev;
    exp_t e;
    irq_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (irq && !irq_prev) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL irq_rise: actual=unexpected IRQ ev=0x%0h pend=%0d required=no IRQ", event_o, pending);
        end else begin
          e = sb_q.pop_front();
          if ({event_o, pending} !== {e.ev, e.pend}) begin
            failures++;
            $display("[TB] FAIL irq_rise: actual ev=0x%0h pend=%0d required ev=0x%0h pend=%0d",
                     event_o, pending, e.ev, e.pend);
          end
        end
      end
      irq_prev = irq;
    end
  end

  // Directed stimulus sequence.
  initial begin
    reset_n = 1'b0;
    ack     = 1'b0;
    clear   = 1'b0;
    apply_stimulus(8'h00, 8'h00, 1'b0);
    tick(3);
    check_output("reset_irq", 32'(irq), 32'h0);
    check_output("reset_event", 32'(event_o), 32'h00);
    check_output("reset_pending", 32'(pending), 32'h0);
    check_output("reset_overflow", 32'(overflow), 32'h0);
    reset_n = 1'b1;
    tick(2);

    $display("[TB] basic detect");
    apply_stimulus(8'h0C, 8'h0F, 1'b1);
    push_exp(8'h0F, 4'd1);
    tick(3);
    check_output("det_pending", 32'(pending), 32'h1);
    check_output("det_event", 32'(event_o), 32'h0F);
    check_output("det_irq_early", 32'(irq), 32'h0);
    tick(1);
    check_output("det_irq", 32'(irq), 32'h1);
    handshake();
    check_output("det_ack_pending", 32'(pending), 32'h0);
    check_output("det_ack_irq", 32'(irq), 32'h0);

    $display("[TB] masking and level");
    apply_stimulus(8'h0C, 8'h00, 1'b1);
    tick(4);
    apply_stimulus(8'h81, 8'h80, 1'b1);
    tick(5);
    check_output("mask_pending", 32'(pending), 32'h0);
    check_output("mask_irq", 32'(irq), 32'h0);
    apply_stimulus(8'h81, 8'h81, 1'b1);
    push_exp(8'h81, 4'd1);
    tick(20);
    check_output("level_pending", 32'(pending), 32'h1);
    handshake();
    check_output("level_ack_pending", 32'(pending), 32'h0);
    apply_stimulus(8'h00, 8'hFF, 1'b1);
    tick(5);
    check_output("trig0_pending", 32'(pending), 32'h0);
    check_output("trig0_irq", 32'(irq), 32'h0);

    $display("[TB] trig change");
    trig = 8'h33;
    push_exp(8'hFF, 4'd1);
    tick(1);
    check_output("trigchg_pending", 32'(pending), 32'h1);
    check_output("trigchg_event", 32'(event_o), 32'hFF);
    tick(1);
    check_output("trigchg_irq", 32'(irq), 32'h1);
    handshake();
    check_output("trigchg_ack_pending", 32'(pending), 32'h0);

    $display("[TB] saturation");
    trig = 8'h00;
    tick(1);
    push_exp(8'hFF, 4'd1);
    for (int i = 0; i < 17; i++) begin
      trig = 8'h33;
      tick(1);
      if (i == 14) begin
        check_output("sat15_pending", 32'(pending), 32'd15);
        check_output("sat15_overflow", 32'(overflow), 32'h0);
      end
      trig = 8'h00;
      tick(1);
    end
    check_output("sat_pending", 32'(pending), 32'd15);
    check_output("sat_overflow", 32'(overflow), 32'h1);
    check_output("sat_irq", 32'(irq), 32'h1);
    for (int j = 1; j <= 15; j++) begin
      if (15 - j > 0) push_exp(8'hFF, 4'(15 - j));
      handshake();
    end
    check_output("drain_pending", 32'(pending), 32'h0);
    check_output("drain_overflow", 32'(overflow), 32'h1);
    check_output("drain_irq", 32'(irq), 32'h0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_output("clear_overflow", 32'(overflow), 32'h0);

    $display("[TB] simultaneous events");
    push_exp(8'hFF, 4'd1);
    trig = 8'h33;
    tick(1);
    trig = 8'h00;
    tick(1);
    trig = 8'h33;
    tick(1);
    check_output("sim_pending2", 32'(pending), 32'd2);
    trig = 8'h00;
    tick(1);
    trig = 8'h33;
    ack  = 1'b1;
    tick(1);
    check_output("sim_hit_ack_pending", 32'(pending), 32'd2);
    check_output("sim_hit_ack_irq", 32'(irq), 32'h0);
    ack = 1'b0;
    push_exp(8'hFF, 4'd2);
    tick(2);
    check_output("sim_reirq", 32'(irq), 32'h1);
    trig = 8'h00;
    tick(1);
    pins = 8'h73;
    tick(2);
    trig  = 8'h33;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_output("clrhit_pending", 32'(pending), 32'h0);
    check_output("clrhit_overflow", 32'(overflow), 32'h0);
    check_output("clrhit_irq", 32'(irq), 32'h0);
    check_output("clrhit_event", 32'(event_o), 32'h73);
    tick(3);
    check_output("clrhit_hold_pending", 32'(pending), 32'h0);
    check_output("clrhit_hold_irq", 32'(irq), 32'h0);

    $display("[TB] reset mid-operation");
    trig = 8'h00;
    tick(1);
    push_exp(8'h73, 4'd1);
    for (int k = 0; k < 3; k++) begin
      trig = 8'h33;
      tick(1);
      trig = 8'h00;
      tick(1);
    end
    check_output("pre_rst_pending", 32'(pending), 32'd3);
    check_output("pre_rst_irq", 32'(irq), 32'h1);
    trig = 8'h33;
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_rst_irq", 32'(irq), 32'h0);
    check_output("async_rst_event", 32'(event_o), 32'h00);
    check_output("async_rst_pending", 32'(pending), 32'h0);
    check_output("async_rst_overflow", 32'(overflow), 32'h0);
    tick(2);
    push_exp(8'h73, 4'd1);
    reset_n = 1'b1;
    tick(3);
    check_output("post_rst_pending", 32'(pending), 32'h1);
    check_output("post_rst_event", 32'(event_o), 32'h73);
    tick(1);
    check_output("post_rst_irq", 32'(irq), 32'h1);
    tick(10);
    check_output("post_rst_single", 32'(pending), 32'h1);
    handshake();
    check_output("post_rst_ack_pending", 32'(pending), 32'h0);

    tick(2);
    check_output("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
